// File: rtl/pipelined_decoder.sv
// RV32 control decoder with a registered output FIFO of up to two decoded control words.
// The illegal-instruction counter tracks every accepted illegal word and saturates.
module pipelined_decoder #(
  parameter int DEPTH      = 2,
  parameter int ENABLE_M   = 0,
  parameter int ENABLE_SYS = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       imm_control,
  output logic             alu_src_a_sel,
  output logic             alu_src_b_sel,
  output logic [1:0]       alu_op,
  output logic [1:0]       rd_src_sel,
  output logic             gpr_wen,
  output logic             mem_wen,
  output logic             is_branch,
  output logic             is_jal,
  output logic             is_jalr,
  output logic             is_mext,
  output logic             is_system,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  typedef struct packed {
    logic [2:0] imm_control;
    logic       alu_src_a_sel;
    logic       alu_src_b_sel;
    logic [1:0] alu_op;
    logic [1:0] rd_src_sel;
    logic       gpr_wen;
    logic       mem_wen;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic       is_mext;
    logic       is_system;
    logic       illegal;
  } ctl_t;

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  ctl_t             dec;
  ctl_t             head;
  ctl_t             mem [2];
  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;
  logic             alive;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             pop;
  logic             unused_bits;

  assign unused_bits = ^instr[24:7];

  always_comb begin
    dec = '0;
    case (instr[6:0])
      7'b0000011: begin dec.alu_src_b_sel = 1'b1; dec.rd_src_sel = 2'b01; dec.gpr_wen = 1'b1; end
      7'b0010011: begin dec.alu_src_b_sel = 1'b1; dec.alu_op = 2'b11; dec.gpr_wen = 1'b1; end
      7'b0010111: begin dec.imm_control = 3'b011; dec.rd_src_sel = 2'b10; dec.gpr_wen = 1'b1; end
      7'b0100011: begin dec.imm_control = 3'b001; dec.alu_src_b_sel = 1'b1; dec.mem_wen = 1'b1; end
      7'b0110011: begin
        if (instr[31:25] == 7'b0000001 && ENABLE_M == 0) begin
          dec.illegal = 1'b1;
        end else begin
          dec.alu_op  = 2'b10;
          dec.gpr_wen = 1'b1;
          dec.is_mext = (instr[31:25] == 7'b0000001);
        end
      end
      7'b0110111: begin
        dec.imm_control = 3'b011; dec.alu_src_a_sel = 1'b1; dec.alu_src_b_sel = 1'b1;
        dec.gpr_wen = 1'b1;
      end
      7'b1100011: begin dec.imm_control = 3'b010; dec.alu_op = 2'b01; dec.is_branch = 1'b1; end
      7'b1100111: begin
        dec.alu_src_b_sel = 1'b1; dec.rd_src_sel = 2'b11; dec.gpr_wen = 1'b1; dec.is_jalr = 1'b1;
      end
      7'b1101111: begin
        dec.imm_control = 3'b100; dec.rd_src_sel = 2'b11; dec.gpr_wen = 1'b1; dec.is_jal = 1'b1;
      end
      // FENCE decodes to a NOP control word when the system extension is on.
      7'b0001111: dec.illegal = (ENABLE_SYS == 0);
      7'b1110011: begin
        dec.is_system = (ENABLE_SYS != 0);
        dec.illegal   = (ENABLE_SYS == 0);
      end
      default:    dec.illegal = 1'b1;
    endcase
  end

  // valid/ready: a word transfers on any edge where valid and ready are both high;
  // in_ready depends only on stored state, and flush wins over a same-cycle push or pop.
  assign in_ready  = alive && (count < DEPTH_C);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  function automatic logic next_ptr(input logic p);
    return (DEPTH == 2) ? ~p : 1'b0;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      alive  <= 1'b0;
      cnt    <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      alive <= 1'b1;
      if (flush) begin
        count  <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= dec;
          wr_ptr      <= next_ptr(wr_ptr);
        end
        if (pop) rd_ptr <= next_ptr(rd_ptr);
        count <= count + {1'b0, push} - {1'b0, pop};
      end
      if (push && dec.illegal && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
  end

  assign head = out_valid ? mem[rd_ptr] : '0;

  assign imm_control   = head.imm_control;
  assign alu_src_a_sel = head.alu_src_a_sel;
  assign alu_src_b_sel = head.alu_src_b_sel;
  assign alu_op        = head.alu_op;
  assign rd_src_sel    = head.rd_src_sel;
  assign gpr_wen       = head.gpr_wen;
  assign mem_wen       = head.mem_wen;
  assign is_branch     = head.is_branch;
  assign is_jal        = head.is_jal;
  assign is_jalr       = head.is_jalr;
  assign is_mext       = head.is_mext;
  assign is_system     = head.is_system;
  assign illegal       = head.illegal;
  assign illegal_count = cnt;

endmodule

// File: tb/tb_pipelined_decoder.sv
// Bench for pipelined_decoder: two instances (base ISA with 2-bit counter, M+SYS enabled)
// share one stimulus stream; a negedge monitor checks both against a reference decoder.
module tb_pipelined_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0;

  always #5 clk = ~clk;

  logic       ir_a, ov_a, sa_a, sb_a, gw_a, mw_a, br_a, jl_a, jr_a, mx_a, sy_a, il_a;
  logic [2:0] imm_a;
  logic [1:0] op_a, rd_a, cnt_a;
  logic       ir_b, ov_b, sa_b, sb_b, gw_b, mw_b, br_b, jl_b, jr_b, mx_b, sy_b, il_b;
  logic [2:0] imm_b;
  logic [1:0] op_b, rd_b;
  logic [15:0] cnt_b;

  pipelined_decoder #(.DEPTH(2), .ENABLE_M(0), .ENABLE_SYS(0), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .instr(instr), .flush(flush),
    .out_valid(ov_a), .out_ready(out_ready), .imm_control(imm_a), .alu_src_a_sel(sa_a),
    .alu_src_b_sel(sb_a), .alu_op(op_a), .rd_src_sel(rd_a), .gpr_wen(gw_a), .mem_wen(mw_a),
    .is_branch(br_a), .is_jal(jl_a), .is_jalr(jr_a), .is_mext(mx_a), .is_system(sy_a),
    .illegal(il_a), .illegal_count(cnt_a));

  pipelined_decoder #(.DEPTH(2), .ENABLE_M(1), .ENABLE_SYS(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b), .instr(instr), .flush(flush),
    .out_valid(ov_b), .out_ready(out_ready), .imm_control(imm_b), .alu_src_a_sel(sa_b),
    .alu_src_b_sel(sb_b), .alu_op(op_b), .rd_src_sel(rd_b), .gpr_wen(gw_b), .mem_wen(mw_b),
    .is_branch(br_b), .is_jal(jl_b), .is_jalr(jr_b), .is_mext(mx_b), .is_system(sy_b),
    .illegal(il_b), .illegal_count(cnt_b));

  wire [16:0] act_a = {imm_a, sa_a, sb_a, op_a, rd_a, gw_a, mw_a, br_a, jl_a, jr_a, mx_a, sy_a, il_a};
  wire [16:0] act_b = {imm_b, sa_b, sb_b, op_b, rd_b, gw_b, mw_b, br_b, jl_b, jr_b, mx_b, sy_b, il_b};

  localparam logic [31:0] ADDI = 32'h00A00093;
  localparam logic [31:0] MUL  = 32'h02B50533;
  localparam logic [31:0] LUI  = 32'h123452B7;
  localparam logic [31:0] JAL  = 32'h0080006F;
  localparam logic [31:0] ONES = 32'hFFFFFFFF;

  int          errors = 0;
  int          checks = 0;
  logic [16:0] exp_qa[$];
  logic [16:0] exp_qb[$];
  int          model_cnt_a = 0;
  int          model_cnt_b = 0;
  bit          just_pushed = 1'b0;
  bit          mon_en = 1'b0;

  // Reference decoder: {imm, a, b, alu_op, rd_src, gpr, mem, br, jal, jalr, mext, sys, illegal}
  function automatic logic [16:0] ref_ctl(logic [31:0] w, bit en_m, bit en_sys);
    logic [2:0] imm;
    logic       a, b, gpr, mem, br, jal, jalr, mx, sys, ill;
    logic [1:0] op, rd;
    bit         mext_f7;
    {imm, a, b, op, rd, gpr, mem, br, jal, jalr, mx, sys, ill} = '0;
    mext_f7 = (w[31:25] == 7'b0000001);
    case (w[6:0])
      7'b0000011: begin b = 1; rd = 2'd1; gpr = 1; end
      7'b0010011: begin b = 1; op = 2'd3; gpr = 1; end
      7'b0010111: begin imm = 3'd3; rd = 2'd2; gpr = 1; end
      7'b0100011: begin imm = 3'd1; b = 1; mem = 1; end
      7'b0110011: if (mext_f7 && !en_m) ill = 1; else begin op = 2'd2; gpr = 1; mx = mext_f7; end
      7'b0110111: begin imm = 3'd3; a = 1; b = 1; gpr = 1; end
      7'b1100011: begin imm = 3'd2; op = 2'd1; br = 1; end
      7'b1100111: begin b = 1; rd = 2'd3; gpr = 1; jalr = 1; end
      7'b1101111: begin imm = 3'd4; rd = 2'd3; gpr = 1; jal = 1; end
      7'b0001111: ill = !en_sys;
      7'b1110011: begin sys = en_sys; ill = !en_sys; end
      default:    ill = 1;
    endcase
    return {imm, a, b, op, rd, gpr, mem, br, jal, jalr, mx, sys, ill};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  ops [12];
    logic [6:0]  f7;
    r   = $urandom();
    ops = '{7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110011, 7'b0110111,
            7'b1100011, 7'b1100111, 7'b1101111, 7'b0001111, 7'b1110011, 7'b0000000};
    ops[11] = r[6:0];
    f7 = ($urandom_range(0, 2) == 0) ? 7'b0000001 : r[31:25];
    return {f7, r[24:7], ops[$urandom_range(0, 11)]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: called just after a rising edge; schedules one cycle of inputs.
  task automatic step(input bit v, input logic [31:0] w, input bit fl, input bit ordy);
    bit          pushed;
    logic [16:0] ea, eb;
    in_valid  = v;
    instr     = w;
    flush     = fl;
    out_ready = ordy;
    ea = ref_ctl(w, 1'b0, 1'b0);
    eb = ref_ctl(w, 1'b1, 1'b1);
    pushed = v && ir_a && !fl;
    if (pushed) begin
      exp_qa.push_back(ea);
      exp_qb.push_back(eb);
    end
    just_pushed = pushed;
    @(posedge clk);
    #1;
    just_pushed = 1'b0;
    if (fl) begin
      exp_qa.delete();
      exp_qb.delete();
    end
    if (pushed && ea[0] && model_cnt_a < 3) model_cnt_a++;
    if (pushed && eb[0] && model_cnt_b < 65535) model_cnt_b++;
  endtask

  // Monitor: compare the presented head against the expected queue; pop on transfer.
  always @(negedge clk) begin
    int vis;
    if (mon_en) begin
      vis = exp_qa.size() - (just_pushed ? 1 : 0);
      chk("a_out_valid", 32'(ov_a), 32'(vis > 0));
      chk("a_in_ready", 32'(ir_a), 32'(vis < 2));
      chk("a_illegal_count", 32'(cnt_a), model_cnt_a);
      chk("b_out_valid", 32'(ov_b), 32'(vis > 0));
      chk("b_in_ready", 32'(ir_b), 32'(vis < 2));
      chk("b_illegal_count", 32'(cnt_b), model_cnt_b);
      if (vis > 0) begin
        chk("a_head", 32'(act_a), 32'(exp_qa[0]));
        chk("b_head", 32'(act_b), 32'(exp_qb[0]));
        if (out_ready && !flush) begin
          void'(exp_qa.pop_front());
          void'(exp_qb.pop_front());
        end
      end else begin
        chk("a_idle_zero", 32'(act_a), 32'd0);
        chk("b_idle_zero", 32'(act_b), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid_a", 32'(ov_a), 0);
    chk("rst_in_ready_a", 32'(ir_a), 0);
    chk("rst_count_a", 32'(cnt_a), 0);
    chk("rst_word_b", 32'(act_b), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_before_first_edge", 32'(ir_a), 0);
    @(posedge clk);
    #1;
    chk("in_ready_first_edge", 32'(ir_a), 1);
    mon_en = 1'b1;

    // addi, latency one
    step(1, ADDI, 0, 1);
    chk("addi_valid", 32'(ov_a), 1);
    chk("addi_word", 32'(act_a), 32'({3'b000, 1'b0, 1'b1, 2'b11, 2'b00, 1'b1, 7'b0}));
    step(0, 0, 0, 1);

    // mul: illegal without M, M-extension with it
    step(1, MUL, 0, 1);
    chk("mul_a_illegal", 32'(il_a), 1);
    chk("mul_a_gpr_wen", 32'(gw_a), 0);
    chk("mul_a_count", 32'(cnt_a), 1);
    chk("mul_b_mext", 32'(mx_b), 1);
    chk("mul_b_alu_op", 32'(op_b), 2);
    chk("mul_b_gpr_wen", 32'(gw_b), 1);
    step(0, 0, 0, 1);

    // stall: three offered, two accepted, then drain in order
    step(1, ADDI, 0, 0);
    step(1, MUL, 0, 0);
    chk("full_in_ready", 32'(ir_a), 0);
    step(1, LUI, 0, 0);
    step(0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1);

    // flush a full buffer with a push offered
    step(1, ADDI, 0, 0);
    step(1, LUI, 0, 0);
    saved = model_cnt_a;
    step(1, ONES, 1, 0);
    chk("flush_full_valid", 32'(ov_a), 0);
    chk("flush_full_in_ready", 32'(ir_a), 1);
    chk("flush_full_count", 32'(cnt_a), 32'(saved));
    // flush beats a same-cycle illegal push
    step(1, ADDI, 0, 0);
    step(1, ONES, 1, 0);
    chk("flush_drop_valid", 32'(ov_a), 0);
    chk("flush_drop_count", 32'(cnt_a), 32'(saved));

    // asynchronous reset with two entries buffered
    step(1, ADDI, 0, 0);
    step(1, JAL, 0, 0);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid_a", 32'(ov_a), 0);
    chk("async_rst_word_a", 32'(act_a), 0);
    chk("async_rst_valid_b", 32'(ov_b), 0);
    chk("async_rst_word_b", 32'(act_b), 0);
    chk("async_rst_count_a", 32'(cnt_a), 0);
    chk("async_rst_in_ready", 32'(ir_a), 0);
    exp_qa.delete();
    exp_qb.delete();
    model_cnt_a = 0;
    model_cnt_b = 0;
    in_valid = 0;
    flush = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // 2-bit counter saturation from zero
    repeat (3) step(1, ONES, 0, 1);
    chk("sat_count_3", 32'(cnt_a), 3);
    repeat (2) step(1, ONES, 0, 1);
    step(0, 0, 0, 1);
    chk("sat_count_5", 32'(cnt_a), 3);
    chk("sat_count_b", 32'(cnt_b), 5);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) != 0);
    end
    repeat (4) step(0, 0, 0, 1);
    chk("final_queue_empty", 32'(exp_qa.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
